// File: rtl/stream_bridge.sv
// Byte-stream bridge to a 2x2 matrix multiply controller: loads A0..A3/B0..B3, waits for done, drains 4 results.
// Optional watchdog on the WAIT phase is built when STREAM_BRIDGE_WDOG_EN is defined.
module stream_bridge #(
   parameter int WDOG_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       load_en,
   output logic       load_sel_ab,
   output logic [1:0] load_index,
   output logic [7:0] in_data,
   input  logic       done,
   output logic       output_en,
   output logic [1:0] output_sel,
   input  logic [7:0] out_data,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       busy,
   output logic       err
);

   // Handshake: a beat moves when valid and ready are both high at a rising edge;
   // valid never waits on ready, and a stalled source keeps its data unchanged.
   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_wdog
      $error("stream_bridge: WDOG_CYCLES must be in 1..255");
   end

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_cnt;
   logic       r_arm;
   logic [1:0] r_idx;
   logic       r_load_en;
   logic       r_load_sel_ab;
   logic [1:0] r_load_index;
   logic [7:0] r_in_data;
   logic       w_xfer;
   logic       w_wdog_fire;

   assign w_xfer = s_valid && (r_state == ST_LOAD);

`ifdef STREAM_BRIDGE_WDOG_EN
   localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);
   logic [7:0] r_wdog;
   logic       r_err;

   assign w_wdog_fire = (r_state == ST_WAIT) && (r_wdog == WDOG_LAST);
   assign err         = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog <= 8'd0;
         r_err  <= 1'b0;
      end else begin
         r_wdog <= (r_state == ST_WAIT) ? r_wdog + 8'd1 : 8'd0;
         if (w_wdog_fire) r_err <= 1'b1;
      end
   end
`else
   assign w_wdog_fire = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   // Arm only after done has been seen low, so a done level left over from the previous batch is ignored.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_LOAD:  if (w_xfer && r_cnt == 3'd7) w_next = ST_WAIT;
         ST_WAIT:  if ((done && r_arm) || w_wdog_fire) w_next = ST_DRAIN;
         ST_DRAIN: if (m_ready && r_idx == 2'd3) w_next = ST_LOAD;
         default:  w_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= 3'd0;
         r_arm         <= 1'b0;
         r_idx         <= 2'd0;
         r_load_en     <= 1'b0;
         r_load_sel_ab <= 1'b0;
         r_load_index  <= 2'd0;
         r_in_data     <= 8'd0;
      end else begin
         r_load_en <= w_xfer;
         if (w_xfer) begin
            r_cnt         <= r_cnt + 3'd1;
            r_load_sel_ab <= r_cnt[2];
            r_load_index  <= r_cnt[1:0];
            r_in_data     <= s_data;
         end
         if (r_state == ST_WAIT) begin
            if (!done) r_arm <= 1'b1;
         end else begin
            r_arm <= 1'b0;
         end
         if (r_state == ST_DRAIN && m_ready) r_idx <= r_idx + 2'd1;
      end
   end

   assign s_ready     = (r_state == ST_LOAD);
   assign busy        = !((r_state == ST_LOAD) && (r_cnt == 3'd0));
   assign load_en     = r_load_en;
   assign load_sel_ab = r_load_sel_ab;
   assign load_index  = r_load_index;
   assign in_data     = r_in_data;
   assign output_en   = (r_state == ST_DRAIN);
   assign output_sel  = r_idx;
   assign m_valid     = (r_state == ST_DRAIN);
   assign m_data      = (r_state == ST_DRAIN) ? out_data : 8'd0;

endmodule

// File: tb/tb_stream_bridge.sv
// Self-checking bench for stream_bridge; a second instance with WDOG_CYCLES=4 covers the watchdog.
module tb_stream_bridge;

`ifdef STREAM_BRIDGE_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam logic [26:0] RST_VEC = 27'h400_0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid, done, m_ready;
   logic       s_ready, load_en, load_sel_ab, output_en, m_valid, busy, err;
   logic [1:0] load_index, output_sel;
   logic [7:0] in_data, out_data, m_data;
   logic       s_ready_wd, load_en_wd, load_sel_ab_wd, output_en_wd, m_valid_wd, busy_wd, err_wd;
   logic [1:0] load_index_wd, output_sel_wd;
   logic [7:0] in_data_wd, out_data_wd, m_data_wd;

   logic [7:0]  tbl[4];
   logic [10:0] exp_q[$];
   logic [26:0] out_vec;
   int          vec_cnt = 0;
   int          err_cnt = 0;

   always #5 clk = ~clk;

   assign out_data    = tbl[output_sel];
   assign out_data_wd = tbl[output_sel_wd];
   assign out_vec = {s_ready, load_en, load_sel_ab, load_index, in_data,
                     output_en, output_sel, m_data, m_valid, busy, err};

   stream_bridge dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .load_en(load_en), .load_sel_ab(load_sel_ab), .load_index(load_index), .in_data(in_data),
      .done(done), .output_en(output_en), .output_sel(output_sel), .out_data(out_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .err(err)
   );

   stream_bridge #(.WDOG_CYCLES(4)) dut_wd (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_wd),
      .load_en(load_en_wd), .load_sel_ab(load_sel_ab_wd), .load_index(load_index_wd),
      .in_data(in_data_wd), .done(done), .output_en(output_en_wd), .output_sel(output_sel_wd),
      .out_data(out_data_wd), .m_data(m_data_wd), .m_valid(m_valid_wd), .m_ready(m_ready),
      .busy(busy_wd), .err(err_wd)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'd0;
      done    = 1'b0;
      m_ready = 1'b0;
      exp_q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; done = 1'b0; m_ready = 1'b0;
      #2;
      vec_cnt++;
      if (out_vec !== RST_VEC) begin
         err_cnt++;
         $display("FAIL reset_async: got %h want %h", out_vec, RST_VEC);
      end
      repeat (2) step();
      vec_cnt++;
      if (out_vec !== RST_VEC) begin
         err_cnt++;
         $display("FAIL reset_held: got %h want %h", out_vec, RST_VEC);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load_seq();
      done = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 1);
         vec_cnt++;
         if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_ready[%0d]: got %b want 1", i, s_ready);
         end
         step();
         vec_cnt++;
         if ({load_en, load_sel_ab, load_index, in_data} !== {1'b1, 1'(i / 4), 2'(i % 4), 8'(i + 1)}) begin
            err_cnt++;
            $display("FAIL load_beat[%0d]: got en=%b sel=%b idx=%0d data=%h want sel=%0d idx=%0d data=%h",
                     i, load_en, load_sel_ab, load_index, in_data, i / 4, i % 4, i + 1);
         end
      end
      vec_cnt++;
      if ({s_ready, busy} !== 2'b01) begin
         err_cnt++;
         $display("FAIL load_full: got ready=%b busy=%b want ready=0 busy=1", s_ready, busy);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         vec_cnt++;
         if ({load_en, m_valid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL wait_ignores_valid[%0d]: got en=%b m_valid=%b want 0 0", i, load_en, m_valid);
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_wait_done();
      done = 1'b1;
      step();
      vec_cnt++;
      if (m_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL stale_done: got m_valid=%b want 0", m_valid);
      end
      done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         vec_cnt++;
         if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_low[%0d]: got m_valid=%b want 0", i, m_valid);
         end
      end
      done = 1'b1;
      step();
      vec_cnt++;
      if ({m_valid, output_en, output_sel} !== 4'b1100) begin
         err_cnt++;
         $display("FAIL drain_entry: got m_valid=%b oe=%b sel=%0d want 1 1 0", m_valid, output_en, output_sel);
      end
   endtask

   task automatic test_drain();
      int k = 0;
      int c = 0;
      for (int i = 0; i < 4; i++) tbl[i] = 8'(8'h10 + i);
      #0;
      while (k < 4 && c < 20) begin
         m_ready = (c % 2 == 0);
         #0;
         vec_cnt++;
         if ({m_valid, output_sel, m_data} !== {1'b1, 2'(k), 8'(8'h10 + k)}) begin
            err_cnt++;
            $display("FAIL drain_beat[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     c, m_valid, output_sel, m_data, k, 8'h10 + k);
         end
         step();
         if (m_ready) k++;
         c++;
      end
      m_ready = 1'b0;
      vec_cnt++;
      if (k != 4 || {s_ready, m_valid, output_en, busy, m_data} !== 12'b1000_0000_0000) begin
         err_cnt++;
         $display("FAIL drain_exit: got beats=%0d ready=%b v=%b oe=%b busy=%b data=%h want 4 1 0 0 0 00",
                  k, s_ready, m_valid, output_en, busy, m_data);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h20 + i);
         step();
      end
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      vec_cnt++;
      if (out_vec !== RST_VEC) begin
         err_cnt++;
         $display("FAIL reset_mid: got %h want %h", out_vec, RST_VEC);
      end
      #2;
      rst_n   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hAA;
      step();
      s_valid = 1'b0;
      vec_cnt++;
      if ({load_en, load_sel_ab, load_index, in_data} !== {1'b1, 1'b0, 2'd0, 8'hAA}) begin
         err_cnt++;
         $display("FAIL reset_restart: got en=%b sel=%b idx=%0d data=%h want 1 0 0 aa",
                  load_en, load_sel_ab, load_index, in_data);
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int b = 0; b < 6; b++) begin
         int k = 0;
         int c = 0;
         int n_stale, n_low;
         logic [10:0] exp;
         done = 1'($urandom_range(0, 1));
         while (k < 8 && c < 64) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            if (s_valid) exp_q.push_back({1'(k / 4), 2'(k % 4), s_data});
            vec_cnt++;
            if (s_ready !== 1'b1) begin
               err_cnt++;
               $display("FAIL rnd_ready[%0d.%0d]: got %b want 1", b, c, s_ready);
            end
            step();
            vec_cnt++;
            if (load_en !== s_valid) begin
               err_cnt++;
               $display("FAIL rnd_load_en[%0d.%0d]: got %b want %b", b, c, load_en, s_valid);
            end
            if (s_valid) begin
               exp = exp_q.pop_front();
               vec_cnt++;
               if ({load_sel_ab, load_index, in_data} !== exp) begin
                  err_cnt++;
                  $display("FAIL rnd_load_beat[%0d.%0d]: got %h want %h", b, k,
                           {load_sel_ab, load_index, in_data}, exp);
               end
               k++;
            end
            c++;
         end
         n_stale = $urandom_range(0, 2);
         n_low   = $urandom_range(1, 3);
         for (int i = 0; i < n_stale + n_low; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            done    = (i < n_stale);
            step();
            vec_cnt++;
            if ({m_valid, m_data, load_en, s_ready} !== 11'd0) begin
               err_cnt++;
               $display("FAIL rnd_wait[%0d.%0d]: got v=%b data=%h en=%b ready=%b want all 0",
                        b, i, m_valid, m_data, load_en, s_ready);
            end
         end
         s_valid = 1'b0;
         done    = 1'b1;
         for (int i = 0; i < 4; i++) tbl[i] = 8'($urandom);
         step();
         k = 0;
         c = 0;
         while (k < 4 && c < 40) begin
            m_ready = 1'($urandom_range(0, 1));
            #0;
            vec_cnt++;
            if ({m_valid, output_sel, m_data} !== {1'b1, 2'(k), tbl[k]}) begin
               err_cnt++;
               $display("FAIL rnd_drain[%0d.%0d]: got v=%b sel=%0d data=%h want 1 %0d %h",
                        b, c, m_valid, output_sel, m_data, k, tbl[k]);
            end
            step();
            if (m_ready) k++;
            c++;
         end
         m_ready = 1'b0;
         vec_cnt++;
         if (k != 4 || {s_ready, m_valid, busy} !== 3'b100) begin
            err_cnt++;
            $display("FAIL rnd_drain_exit[%0d]: got beats=%0d ready=%b v=%b busy=%b want 4 1 0 0",
                     b, k, s_ready, m_valid, busy);
         end
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = 8'($urandom);
         step();
      end
      s_valid = 1'b0;
      done    = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (i < 4) begin
            vec_cnt++;
            if ({m_valid_wd, err_wd} !== 2'b00) begin
               err_cnt++;
               $display("FAIL wdog_early[%0d]: got v=%b err=%b want 0 0", i, m_valid_wd, err_wd);
            end
         end
      end
      vec_cnt++;
      if ({m_valid_wd, err_wd} !== {WD_EN, WD_EN}) begin
         err_cnt++;
         $display("FAIL wdog_fire: got v=%b err=%b want %b %b", m_valid_wd, err_wd, WD_EN, WD_EN);
      end
      vec_cnt++;
      if ({m_valid, err} !== 2'b00) begin
         err_cnt++;
         $display("FAIL wdog_long_wait: got v=%b err=%b want 0 0", m_valid, err);
      end
      m_ready = 1'b1;
      repeat (4) step();
      m_ready = 1'b0;
      vec_cnt++;
      if ({s_ready_wd, err_wd} !== {WD_EN, WD_EN}) begin
         err_cnt++;
         $display("FAIL wdog_sticky: got ready=%b err=%b want %b %b", s_ready_wd, err_wd, WD_EN, WD_EN);
      end
      do_reset();
      vec_cnt++;
      if (err_wd !== 1'b0) begin
         err_cnt++;
         $display("FAIL wdog_clear: got err=%b want 0", err_wd);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tbl[i] = 8'd0;
      test_reset();
      test_load_seq();
      test_wait_done();
      test_drain();
      test_reset_mid();
      test_random();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
